// File: rtl/typepkg.sv
// Shared core types: memory-op encodings, the poison value, and LSU state.
package typepkg;

  typedef enum logic [2:0] {
    MR_NONE   = 3'd0,
    MR_BYTE   = 3'd1,
    MR_HALF   = 3'd2,
    MR_WORD   = 3'd3,
    MR_BYTE_U = 3'd4,
    MR_HALF_U = 3'd5
  } mem_read_t;

  typedef enum logic [1:0] {
    MW_NONE = 2'd0,
    MW_BYTE = 2'd1,
    MW_HALF = 2'd2,
    MW_WORD = 2'd3
  } mem_write_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } acc_size_t;

  localparam logic [31:0] BAD_VAL = 32'hDEAD_BEEF;

  // Access width of an op; a read control takes precedence over a write.
  function automatic acc_size_t op_size(mem_read_t rd, mem_write_t wr);
    acc_size_t sz;
    sz = SZ_NONE;
    if (rd != MR_NONE) begin
      case (rd)
        MR_BYTE, MR_BYTE_U: sz = SZ_BYTE;
        MR_HALF, MR_HALF_U: sz = SZ_HALF;
        default:            sz = SZ_WORD;
      endcase
    end else begin
      case (wr)
        MW_BYTE: sz = SZ_BYTE;
        MW_HALF: sz = SZ_HALF;
        MW_WORD: sz = SZ_WORD;
        default: sz = SZ_NONE;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_lane_align.sv
// Byte-lane steering for the LSU: store enables/replication, misalignment
// detection, and load extraction with sign/zero extension.
module lsu_lane_align
  import typepkg::*;
(
  input  mem_read_t   st_rd_i,
  input  mem_write_t  st_wr_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  output logic        st_misal_o,
  input  mem_read_t   ld_rd_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  acc_size_t   sz;
  logic [31:0] shifted;

  assign sz = op_size(st_rd_i, st_wr_i);

  // Outgoing lanes: enables shifted to the byte offset, data replicated so
  // every lane the enables select carries the right byte.
  always_comb begin
    st_be_o    = 4'b0000;
    st_wdata_o = st_wdata_i;
    st_misal_o = 1'b0;
    case (sz)
      SZ_BYTE: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        st_be_o    = 4'b0011 << st_off_i;
        st_wdata_o = {2{st_wdata_i[15:0]}};
        st_misal_o = st_off_i[0];
      end
      SZ_WORD: begin
        st_be_o    = 4'b1111;
        st_misal_o = (st_off_i != 2'b00);
      end
      default: ;
    endcase
  end

  assign shifted = ld_rdata_i >> {ld_off_i, 3'b000};

  // Incoming lanes: bring the addressed bytes down to bit 0 and extend.
  always_comb begin
    ld_data_o = shifted;
    case (ld_rd_i)
      MR_BYTE:   ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
      MR_BYTE_U: ld_data_o = {24'd0, shifted[7:0]};
      MR_HALF:   ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
      MR_HALF_U: ld_data_o = {16'd0, shifted[15:0]};
      default:   ld_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// RV32I memory stage: one req/gnt/rvalid transaction per op, registered
// write-back result, back-pressure to EX while an op is in flight.
module lsu_mem_stage
  import typepkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  mem_read_t   ex_mem_read,
  input  mem_write_t  ex_mem_write,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        dmem_req,
  input  logic        dmem_gnt,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_rdata,
  output logic        wb_misaligned,
  output logic        wb_bus_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  mem_read_t   rd_q;
  logic [1:0]  off_q;
  logic        load_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] wb_rdata_q;
  logic        mis_q, err_q;

  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;
  logic        st_misal;
  logic        accept, ex_load, ex_none, timeout;

  assign accept  = (state_q == LSU_IDLE) && ex_valid;
  assign ex_load = (ex_mem_read != MR_NONE);
  assign ex_none = (ex_mem_read == MR_NONE) && (ex_mem_write == MW_NONE);
  assign timeout = (cnt_q == CNT_LAST);

  lsu_lane_align u_align (
    .st_rd_i    (ex_mem_read),
    .st_wr_i    (ex_mem_write),
    .st_off_i   (ex_addr[1:0]),
    .st_wdata_i (ex_wdata),
    .st_be_o    (st_be),
    .st_wdata_o (st_wdata),
    .st_misal_o (st_misal),
    .ld_rd_i    (rd_q),
    .ld_off_i   (off_q),
    .ld_rdata_i (dmem_rdata),
    .ld_data_o  (ld_data)
  );

  // Next state and response-timeout counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LSU_IDLE: if (ex_valid) state_d = (st_misal || ex_none) ? LSU_RESP : LSU_REQ;
      LSU_REQ:  if (dmem_gnt) begin
                  state_d = LSU_WAIT;
                  cnt_d   = 8'd0;
                end
      LSU_WAIT: if (dmem_rvalid || timeout) state_d = LSU_RESP;
                else cnt_d = cnt_q + 8'd1;
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Op capture at accept; result capture on the response or the timeout.
  // The result defaults to the poison value so stores, NONE ops, faults
  // and timeouts all report it without extra muxing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q       <= MR_NONE;
      off_q      <= 2'd0;
      load_q     <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wb_rdata_q <= 32'd0;
      mis_q      <= 1'b0;
      err_q      <= 1'b0;
    end else if (accept) begin
      rd_q       <= ex_mem_read;
      off_q      <= ex_addr[1:0];
      load_q     <= ex_load;
      we_q       <= !ex_load && (ex_mem_write != MW_NONE);
      be_q       <= st_be;
      addr_q     <= {ex_addr[31:2], 2'b00};
      wdata_q    <= st_wdata;
      wb_rdata_q <= BAD_VAL;
      mis_q      <= st_misal;
      err_q      <= 1'b0;
    end else if (state_q == LSU_WAIT) begin
      if (dmem_rvalid) begin
        if (load_q) wb_rdata_q <= ld_data;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  // Both controls active at once is illegal input; the read wins in the datapath.
  always_ff @(posedge clk) begin
    if (!rst && accept) assert (!((ex_mem_read != MR_NONE) && (ex_mem_write != MW_NONE)));
  end

  assign ex_ready      = (state_q == LSU_IDLE);
  assign dmem_req      = (state_q == LSU_REQ);
  assign wb_valid      = (state_q == LSU_RESP);
  assign dmem_we       = we_q;
  assign dmem_be       = be_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign wb_rdata      = wb_rdata_q;
  assign wb_misaligned = mis_q;
  assign wb_bus_err    = err_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with TIMEOUT_CYCLES=4.
module tb_lsu_mem_stage;
  import typepkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  mem_read_t   ex_mem_read = MR_NONE;
  mem_write_t  ex_mem_write = MW_NONE;
  logic [31:0] ex_addr = 32'd0;
  logic [31:0] ex_wdata = 32'd0;
  logic        dmem_req;
  logic        dmem_gnt = 1'b0;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        wb_valid;
  logic [31:0] wb_rdata;
  logic        wb_misaligned;
  logic        wb_bus_err;

  int vectors = 0;
  int miscompares = 0;

  lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_addr       (ex_addr),
    .ex_wdata      (ex_wdata),
    .dmem_req      (dmem_req),
    .dmem_gnt      (dmem_gnt),
    .dmem_we       (dmem_we),
    .dmem_be       (dmem_be),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_rdata      (wb_rdata),
    .wb_misaligned (wb_misaligned),
    .wb_bus_err    (wb_bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input mem_read_t rd, input mem_write_t wr,
                         input logic [31:0] a, input logic [31:0] wd);
    ex_valid     = 1'b1;
    ex_mem_read  = rd;
    ex_mem_write = wr;
    ex_addr      = a;
    ex_wdata     = wd;
  endtask

  task automatic idle_ex();
    ex_valid     = 1'b0;
    ex_mem_read  = MR_NONE;
    ex_mem_write = MW_NONE;
  endtask

  // Best-case bus op: accept, REQ+gnt, rvalid, wb_valid, back to IDLE.
  task automatic bus_op(input string tag, input mem_read_t rd, input mem_write_t wr,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                        input logic [3:0] e_be, input logic [31:0] e_wd, input logic e_we,
                        input logic [31:0] e_res);
    present(rd, wr, a, wd);
    chk1({tag, ".ready_c0"}, ex_ready, 1'b1);
    chk1({tag, ".req_c0"}, dmem_req, 1'b0);
    tick();
    idle_ex();
    chk1({tag, ".req_c1"}, dmem_req, 1'b1);
    chk1({tag, ".ready_c1"}, ex_ready, 1'b0);
    chk32({tag, ".addr"}, dmem_addr, {a[31:2], 2'b00});
    chk4({tag, ".be"}, dmem_be, e_be);
    chk1({tag, ".we"}, dmem_we, e_we);
    if (e_we) chk32({tag, ".wdata"}, dmem_wdata, e_wd);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt    = 1'b0;
    chk1({tag, ".req_c2"}, dmem_req, 1'b0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdat;
    tick();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'd0;
    chk1({tag, ".wbv_c3"}, wb_valid, 1'b1);
    chk32({tag, ".rdata"}, wb_rdata, e_res);
    chk1({tag, ".mis"}, wb_misaligned, 1'b0);
    chk1({tag, ".err"}, wb_bus_err, 1'b0);
    tick();
    chk1({tag, ".wbv_c4"}, wb_valid, 1'b0);
    chk1({tag, ".ready_c4"}, ex_ready, 1'b1);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk1("rst.ready", ex_ready, 1'b1);
    chk1("rst.req", dmem_req, 1'b0);
    chk1("rst.wbv", wb_valid, 1'b0);
    chk32("rst.rdata", wb_rdata, 32'd0);
    chk4("rst.be", dmem_be, 4'd0);
    chk1("rst.we", dmem_we, 1'b0);
    rst = 1'b0;
    tick();

    // Loads and stores with lane steering
    bus_op("lb",  MR_BYTE,   MW_NONE, 32'h0000_1003, 32'd0, 32'h80FF_1234, 4'b1000, 32'd0, 1'b0, 32'hFFFF_FF80);
    bus_op("lbu", MR_BYTE_U, MW_NONE, 32'h0000_1003, 32'd0, 32'h80FF_1234, 4'b1000, 32'd0, 1'b0, 32'h0000_0080);
    bus_op("lh",  MR_HALF,   MW_NONE, 32'h0000_1002, 32'd0, 32'h80FF_1234, 4'b1100, 32'd0, 1'b0, 32'hFFFF_80FF);
    bus_op("lhu", MR_HALF_U, MW_NONE, 32'h0000_1002, 32'd0, 32'h80FF_1234, 4'b1100, 32'd0, 1'b0, 32'h0000_80FF);
    bus_op("lw",  MR_WORD,   MW_NONE, 32'h0000_1000, 32'd0, 32'h80FF_1234, 4'b1111, 32'd0, 1'b0, 32'h80FF_1234);
    bus_op("sh",  MR_NONE,   MW_HALF, 32'h0000_2002, 32'h0000_BEEF, 32'h1111_2222, 4'b1100, 32'hBEEF_BEEF, 1'b1, 32'hDEAD_BEEF);
    bus_op("sb",  MR_NONE,   MW_BYTE, 32'h0000_2001, 32'h1234_5678, 32'd0, 4'b0010, 32'h7878_7878, 1'b1, 32'hDEAD_BEEF);
    bus_op("sw",  MR_NONE,   MW_WORD, 32'h0000_2004, 32'hA5A5_0F0F, 32'd0, 4'b1111, 32'hA5A5_0F0F, 1'b1, 32'hDEAD_BEEF);

    // Misaligned LW: result the cycle after accept, no bus request
    present(MR_WORD, MW_NONE, 32'h0000_3001, 32'd0);
    tick();
    idle_ex();
    chk1("mis_lw.req", dmem_req, 1'b0);
    chk1("mis_lw.wbv", wb_valid, 1'b1);
    chk1("mis_lw.mis", wb_misaligned, 1'b1);
    chk1("mis_lw.err", wb_bus_err, 1'b0);
    chk32("mis_lw.rdata", wb_rdata, 32'hDEAD_BEEF);
    chk1("mis_lw.ready", ex_ready, 1'b0);
    tick();
    chk1("mis_lw.wbv_after", wb_valid, 1'b0);
    chk1("mis_lw.ready_after", ex_ready, 1'b1);

    // Misaligned SH at odd address
    present(MR_NONE, MW_HALF, 32'h0000_3003, 32'h0000_1234);
    tick();
    idle_ex();
    chk1("mis_sh.req", dmem_req, 1'b0);
    chk1("mis_sh.wbv", wb_valid, 1'b1);
    chk1("mis_sh.mis", wb_misaligned, 1'b1);
    tick();

    // NONE/NONE op: result next cycle, no bus, no flags
    present(MR_NONE, MW_NONE, 32'h0000_3000, 32'd0);
    tick();
    idle_ex();
    chk1("none.req", dmem_req, 1'b0);
    chk1("none.wbv", wb_valid, 1'b1);
    chk1("none.mis", wb_misaligned, 1'b0);
    chk1("none.err", wb_bus_err, 1'b0);
    chk32("none.rdata", wb_rdata, 32'hDEAD_BEEF);
    tick();

    // Timeout: gnt in cycle g, no rvalid, bus error in g+5
    present(MR_WORD, MW_NONE, 32'h0000_4000, 32'd0);
    tick();
    idle_ex();
    chk1("to.req", dmem_req, 1'b1);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk1($sformatf("to.wbv_g%0d", k), wb_valid, 1'b0);
      tick();
    end
    chk1("to.wbv_g5", wb_valid, 1'b1);
    chk1("to.err", wb_bus_err, 1'b1);
    chk1("to.mis", wb_misaligned, 1'b0);
    chk32("to.rdata", wb_rdata, 32'hDEAD_BEEF);
    tick();
    chk1("to.ready_after", ex_ready, 1'b1);
    chk1("to.wbv_after", wb_valid, 1'b0);

    // Back-pressure: gnt withheld, second op held on EX until IDLE
    present(MR_WORD, MW_NONE, 32'h0000_5004, 32'd0);
    tick();
    present(MR_NONE, MW_WORD, 32'h0000_6000, 32'h0123_4567);
    for (int k = 0; k < 3; k++) begin
      chk1($sformatf("bp.req%0d", k), dmem_req, 1'b1);
      chk1($sformatf("bp.ready%0d", k), ex_ready, 1'b0);
      chk32($sformatf("bp.addr%0d", k), dmem_addr, 32'h0000_5004);
      chk4($sformatf("bp.be%0d", k), dmem_be, 4'b1111);
      chk1($sformatf("bp.we%0d", k), dmem_we, 1'b0);
      if (k < 2) tick();
    end
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk32("bp.addr_wait", dmem_addr, 32'h0000_5004);
    chk1("bp.ready_wait", ex_ready, 1'b0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFE_F00D;
    tick();
    dmem_rvalid = 1'b0;
    chk1("bp.wbv", wb_valid, 1'b1);
    chk32("bp.rdata", wb_rdata, 32'hCAFE_F00D);
    chk1("bp.ready_resp", ex_ready, 1'b0);
    tick();
    chk1("bp.ready_idle", ex_ready, 1'b1);
    tick();
    idle_ex();
    chk1("bp2.req", dmem_req, 1'b1);
    chk32("bp2.addr", dmem_addr, 32'h0000_6000);
    chk1("bp2.we", dmem_we, 1'b1);
    chk32("bp2.wdata", dmem_wdata, 32'h0123_4567);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    chk1("bp2.wbv", wb_valid, 1'b1);
    chk32("bp2.rdata", wb_rdata, 32'hDEAD_BEEF);
    tick();

    // Reset while in WAIT: immediate IDLE, late rvalid ignored
    present(MR_WORD, MW_NONE, 32'h0000_7000, 32'd0);
    tick();
    idle_ex();
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk1("rw.req_wait", dmem_req, 1'b0);
    chk1("rw.ready_wait", ex_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk1("rw.req_async", dmem_req, 1'b0);
    chk1("rw.ready_async", ex_ready, 1'b1);
    tick();
    rst         = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_AAAA;
    tick();
    dmem_rvalid = 1'b0;
    chk1("rw.wbv1", wb_valid, 1'b0);
    tick();
    chk1("rw.wbv2", wb_valid, 1'b0);
    chk1("rw.ready_end", ex_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
